// File: rtl/alu_pkg.sv
// Shared widths and the registered result bundle for the integer ALU.
package alu_pkg;

   localparam int ALU_WIDTH = 32;
   localparam int ALU_SHW   = 5;

   typedef struct packed {
      logic [ALU_WIDTH-1:0] summ;
      logic                 ocarry;
      logic [ALU_WIDTH-1:0] mult_h;
      logic [ALU_WIDTH-1:0] mult_l;
      logic [ALU_WIDTH-1:0] zand;
      logic [ALU_WIDTH-1:0] zor;
      logic [ALU_WIDTH-1:0] zxor;
      logic [ALU_WIDTH-1:0] znot;
      logic [ALU_WIDTH-1:0] sub;
      logic [ALU_WIDTH-1:0] ashiftl;
      logic [ALU_WIDTH-1:0] ashiftr;
      logic [ALU_WIDTH-1:0] lshiftl;
      logic [ALU_WIDTH-1:0] lshiftr;
   } alu_res_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shifter: four shift flavours of x by the full value of y,
// saturating to zero (or sign copies for ashiftr) once y reaches WIDTH.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] ashiftl,
   output logic [WIDTH-1:0] ashiftr,
   output logic [WIDTH-1:0] lshiftl,
   output logic [WIDTH-1:0] lshiftr
);

   logic signed [WIDTH-1:0] x_s;
   logic [SHW-1:0]          amt;
   logic                    over;

   assign x_s  = x;
   assign amt  = y[SHW-1:0];
   // Any set bit above the amount field means the shift is at least WIDTH.
   assign over = |y[WIDTH-1:SHW];

   always_comb begin
      lshiftl = '0;
      lshiftr = '0;
      ashiftr = {WIDTH{x[WIDTH-1]}};
      if (!over) begin
         lshiftl = x << amt;
         lshiftr = x >> amt;
         ashiftr = x_s >>> amt;
      end
   end

   assign ashiftl = lshiftl;

endmodule

// File: rtl/alu_unit.sv
// Integer ALU: all results computed in parallel, registered once (latency 1).
// Define ALU_MULT_EN to build the unsigned multiplier; otherwise mult_h/mult_l are 0.
module alu_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             carry,
   output logic [WIDTH-1:0] summ,
   output logic             ocarry,
   output logic [WIDTH-1:0] mult_h,
   output logic [WIDTH-1:0] mult_l,
   output logic [WIDTH-1:0] zand,
   output logic [WIDTH-1:0] zor,
   output logic [WIDTH-1:0] zxor,
   output logic [WIDTH-1:0] znot,
   output logic [WIDTH-1:0] sub,
   output logic [WIDTH-1:0] ashiftl,
   output logic [WIDTH-1:0] ashiftr,
   output logic [WIDTH-1:0] lshiftl,
   output logic [WIDTH-1:0] lshiftr
);

   localparam int SHW = $clog2(WIDTH);

   alu_res_t         res_p0;
   alu_res_t         res_p1;
   logic [WIDTH:0]   sum_p0;
   logic [2*WIDTH-1:0] prod_p0;
   logic [WIDTH-1:0] ashiftl_p0;
   logic [WIDTH-1:0] ashiftr_p0;
   logic [WIDTH-1:0] lshiftl_p0;
   logic [WIDTH-1:0] lshiftr_p0;

   // Stage p0: combinational compute
   assign sum_p0 = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, carry};

`ifdef ALU_MULT_EN
   assign prod_p0 = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
`else
   assign prod_p0 = '0;
`endif

   alu_shifter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_shifter (
      .x       (x),
      .y       (y),
      .ashiftl (ashiftl_p0),
      .ashiftr (ashiftr_p0),
      .lshiftl (lshiftl_p0),
      .lshiftr (lshiftr_p0)
   );

   always_comb begin
      res_p0         = '0;
      res_p0.summ    = sum_p0[WIDTH-1:0];
      res_p0.ocarry  = sum_p0[WIDTH];
      res_p0.mult_h  = prod_p0[2*WIDTH-1:WIDTH];
      res_p0.mult_l  = prod_p0[WIDTH-1:0];
      res_p0.zand    = x & y;
      res_p0.zor     = x | y;
      res_p0.zxor    = x ^ y;
      res_p0.znot    = ~x;
      res_p0.sub     = x - y;
      res_p0.ashiftl = ashiftl_p0;
      res_p0.ashiftr = ashiftr_p0;
      res_p0.lshiftl = lshiftl_p0;
      res_p0.lshiftr = lshiftr_p0;
   end

   // Stage p1: output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_p1 <= '0;
      end else begin
         res_p1 <= res_p0;
      end
   end

   assign summ    = res_p1.summ;
   assign ocarry  = res_p1.ocarry;
   assign mult_h  = res_p1.mult_h;
   assign mult_l  = res_p1.mult_l;
   assign zand    = res_p1.zand;
   assign zor     = res_p1.zor;
   assign zxor    = res_p1.zxor;
   assign znot    = res_p1.znot;
   assign sub     = res_p1.sub;
   assign ashiftl = res_p1.ashiftl;
   assign ashiftr = res_p1.ashiftr;
   assign lshiftl = res_p1.lshiftl;
   assign lshiftr = res_p1.lshiftr;

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit; multiplier expectations follow ALU_MULT_EN.
module tb_alu_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] x;
   logic [31:0] y;
   logic        carry;
   logic [31:0] summ;
   logic        ocarry;
   logic [31:0] mult_h;
   logic [31:0] mult_l;
   logic [31:0] zand;
   logic [31:0] zor;
   logic [31:0] zxor;
   logic [31:0] znot;
   logic [31:0] sub;
   logic [31:0] ashiftl;
   logic [31:0] ashiftr;
   logic [31:0] lshiftl;
   logic [31:0] lshiftr;

   int total = 0;
   int bad   = 0;

   alu_unit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .x       (x),
      .y       (y),
      .carry   (carry),
      .summ    (summ),
      .ocarry  (ocarry),
      .mult_h  (mult_h),
      .mult_l  (mult_l),
      .zand    (zand),
      .zor     (zor),
      .zxor    (zxor),
      .znot    (znot),
      .sub     (sub),
      .ashiftl (ashiftl),
      .ashiftr (ashiftr),
      .lshiftl (lshiftl),
      .lshiftr (lshiftr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   // Drive operands mid-cycle, then sample just after the capturing edge.
   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic c);
      @(negedge clk);
      x     = a;
      y     = b;
      carry = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_shifts(input string tag, input logic [31:0] l, input logic [31:0] ar,
                             input logic [31:0] lr);
      chk({tag, "_ashiftl"}, ashiftl, l);
      chk({tag, "_lshiftl"}, lshiftl, l);
      chk({tag, "_ashiftr"}, ashiftr, ar);
      chk({tag, "_lshiftr"}, lshiftr, lr);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_summ"},    summ, 32'h0);
      chk({tag, "_ocarry"},  {31'h0, ocarry}, 32'h0);
      chk({tag, "_mult_h"},  mult_h, 32'h0);
      chk({tag, "_mult_l"},  mult_l, 32'h0);
      chk({tag, "_zand"},    zand, 32'h0);
      chk({tag, "_zor"},     zor, 32'h0);
      chk({tag, "_zxor"},    zxor, 32'h0);
      chk({tag, "_znot"},    znot, 32'h0);
      chk({tag, "_sub"},     sub, 32'h0);
      chk_shifts(tag, 32'h0, 32'h0, 32'h0);
   endtask

   // Expected product halves depend on whether the multiplier is built.
   function automatic logic [31:0] mexp(input logic [31:0] v);
`ifdef ALU_MULT_EN
      return v;
`else
      return 32'h0;
`endif
   endfunction

   initial begin
      rst_n = 1'b0;
      x     = 32'hDEAD_BEEF;
      y     = 32'h1234_5678;
      carry = 1'b1;
      #12;
      chk_all_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;

      apply(32'd2, 32'd6, 1'b0);
      chk("a0_summ", summ, 32'd8);
      chk("a0_mult_h", mult_h, 32'h0);
      chk("a0_mult_l", mult_l, mexp(32'd12));
      chk("a0_sub", sub, 32'hFFFF_FFFC);
      chk_shifts("a0", 32'd128, 32'h0, 32'h0);

      apply(32'd2, 32'd6, 1'b1);
      chk("a1_summ", summ, 32'd9);
      chk("a1_ocarry", {31'h0, ocarry}, 32'h0);
      chk("a1_mult_l", mult_l, mexp(32'd12));
      chk("a1_sub", sub, 32'hFFFF_FFFC);

      apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("ones_ocarry", {31'h0, ocarry}, 32'h1);
      chk("ones_summ", summ, 32'hFFFF_FFFE);
      chk("ones_mult_h", mult_h, mexp(32'hFFFF_FFFE));
      chk("ones_mult_l", mult_l, mexp(32'h0000_0001));
      chk_shifts("ones", 32'h0, 32'hFFFF_FFFF, 32'h0);

      apply(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      chk("m7_mult_h", mult_h, mexp(32'h3FFF_FFFF));
      chk("m7_mult_l", mult_l, mexp(32'h0000_0001));
      chk("m7_summ", summ, 32'hFFFF_FFFE);
      chk("m7_ocarry", {31'h0, ocarry}, 32'h0);

      apply(32'h3333_3333, 32'hF0A5_C96B, 1'b0);
      chk("lg_zand", zand, 32'h3021_0123);
      chk("lg_zor", zor, 32'hF3B7_FB7B);
      chk("lg_zxor", zxor, 32'hC396_FA58);
      chk("lg_znot", znot, 32'hCCCC_CCCC);
      chk("lg_summ", summ, 32'h23D8_FC9E);
      chk("lg_ocarry", {31'h0, ocarry}, 32'h1);

      apply(32'd10, -32'sd20, 1'b0);
      chk("neg_summ", summ, 32'hFFFF_FFF6);
      chk("neg_sub", sub, 32'd30);
      chk("neg_ocarry", {31'h0, ocarry}, 32'h0);

      apply(32'd10, -32'sd20, 1'b1);
      chk("negc_summ", summ, 32'hFFFF_FFF7);
      chk("negc_sub", sub, 32'd30);

      apply(32'h8000_0301, 32'd2, 1'b0);
      chk_shifts("sh2", 32'h0000_0C04, 32'hE000_00C0, 32'h2000_00C0);
      apply(32'h8000_0301, 32'd40, 1'b0);
      chk_shifts("sh40", 32'h0, 32'hFFFF_FFFF, 32'h0);
      apply(32'h8000_0301, 32'd0, 1'b0);
      chk_shifts("sh0", 32'h8000_0301, 32'h8000_0301, 32'h8000_0301);
      apply(32'h8000_0301, 32'd31, 1'b0);
      chk_shifts("sh31", 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001);
      apply(32'h8000_0301, 32'd32, 1'b0);
      chk_shifts("sh32", 32'h0, 32'hFFFF_FFFF, 32'h0);
      apply(32'h4000_0301, 32'h0000_0101, 1'b0);
      chk_shifts("sh257", 32'h0, 32'h0, 32'h0);
      apply(32'h4000_0301, 32'd1, 1'b0);
      chk_shifts("sh1p", 32'h8000_0602, 32'h2000_0180, 32'h2000_0180);

      // Outputs must hold while inputs move between edges.
      @(negedge clk);
      x = 32'h0000_0005;
      y = 32'h0000_0007;
      #1;
      chk("hold_summ", summ, 32'h4000_0302);
      chk("hold_lshiftl", lshiftl, 32'h8000_0602);

      // Asynchronous reset between edges clears everything at once.
      rst_n = 1'b0;
      #1;
      chk_all_zero("arst");
      @(posedge clk);
      #1;
      chk_all_zero("arst_edge");

      @(negedge clk);
      rst_n = 1'b1;
      x     = 32'd5;
      y     = 32'd3;
      carry = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_summ", summ, 32'd9);
      chk("rel_sub", sub, 32'd2);
      chk("rel_mult_l", mult_l, mexp(32'd15));
      chk("rel_lshiftl", lshiftl, 32'd40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
